// File: rtl/branch_unit_bht_pkg.sv
// Shared definitions for the decode-stage branch unit: condition encodings,
// 2-bit counter states and saturating counter helpers.
package branch_pkg;

   // Branch condition select encodings (11x are reserved and resolve not-taken)
   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLEZ = 3'b010;
   localparam logic [2:0] BR_BGTZ = 3'b011;
   localparam logic [2:0] BR_BLTZ = 3'b100;
   localparam logic [2:0] BR_BGEZ = 3'b101;

   // 2-bit direction counter states
   localparam logic [1:0] CTR_SNT = 2'd0;
   localparam logic [1:0] CTR_WNT = 2'd1;
   localparam logic [1:0] CTR_WT  = 2'd2;
   localparam logic [1:0] CTR_ST  = 2'd3;

   typedef logic [1:0] ctr_t;

   // Saturating increment of a 2-bit counter (sticks at strongly taken)
   function automatic ctr_t sat_inc(input ctr_t v);
      if (v == CTR_ST) begin
         return CTR_ST;
      end else begin
         return v + 2'd1;
      end
   endfunction

   // Saturating decrement of a 2-bit counter (sticks at strongly not-taken)
   function automatic ctr_t sat_dec(input ctr_t v);
      if (v == CTR_SNT) begin
         return CTR_SNT;
      end else begin
         return v - 2'd1;
      end
   endfunction

endpackage

// File: rtl/branch_unit_bht_if.sv
// Bundle of fetch/decode/statistics signals between the pipeline and the
// branch unit. slave is the branch unit's view, master the pipeline's view.
interface branch_unit_bht_if #(
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int STAT_W = 16
);
   logic [PC_W-1:0]   PC_F;
   logic              PredTaken_F;
   logic [PC_W-1:0]   PC_D;
   logic              PredTaken_D;
   logic              Branch_D;
   logic [2:0]        BrOp_D;
   logic [DATA_W-1:0] SrcA_D;
   logic [DATA_W-1:0] SrcB_D;
   logic              Stall_D;
   logic              StatClr;
   logic              PCSrc_D;
   logic              Mispredict_D;
   logic [STAT_W-1:0] BrCount;
   logic [STAT_W-1:0] MissCount;

   modport slave (
      input  PC_F, PC_D, PredTaken_D, Branch_D, BrOp_D, SrcA_D, SrcB_D,
             Stall_D, StatClr,
      output PredTaken_F, PCSrc_D, Mispredict_D, BrCount, MissCount
   );

   modport master (
      output PC_F, PC_D, PredTaken_D, Branch_D, BrOp_D, SrcA_D, SrcB_D,
             Stall_D, StatClr,
      input  PredTaken_F, PCSrc_D, Mispredict_D, BrCount, MissCount
   );
endinterface

// File: rtl/branch_unit_bht_cond.sv
// Combinational branch condition evaluator. Zero compares treat SrcA_D as
// signed, so they only need the sign bit and an all-zero detect.
module branch_cond
   import branch_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        BrOp_D,
   input  logic [DATA_W-1:0] SrcA_D,
   input  logic [DATA_W-1:0] SrcB_D,
   output logic              cond
);

   logic a_neg_s;
   logic a_zero_s;

   assign a_neg_s  = SrcA_D[DATA_W-1];
   assign a_zero_s = (SrcA_D == {DATA_W{1'b0}});

   // Select the condition result for the requested branch type
   always_comb begin
      cond = 1'b0;
      case (BrOp_D)
         BR_BEQ:  cond = (SrcA_D == SrcB_D);
         BR_BNE:  cond = (SrcA_D != SrcB_D);
         BR_BLEZ: cond = a_neg_s | a_zero_s;
         BR_BGTZ: cond = ~a_neg_s & ~a_zero_s;
         BR_BLTZ: cond = a_neg_s;
         BR_BGEZ: cond = ~a_neg_s;
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_unit_bht.sv
// Decode-stage branch resolution with a fetch-side 2-bit branch history
// table. Resolves the branch, flags mispredictions, trains the table and
// keeps saturating branch/mispredict statistics.
module branch_unit_bht
   import branch_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int PC_W      = 32,
   parameter int BHT_DEPTH = 64,
   parameter int CTR_INIT  = 1,
   parameter int STAT_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   branch_unit_bht_if.slave   bus
);

   localparam int   IDX_W    = $clog2(BHT_DEPTH);
   localparam ctr_t CTR_RST  = 2'(CTR_INIT);
   localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

   ctr_t              bht_r [BHT_DEPTH];
   logic [IDX_W-1:0]  idx_f_s;
   logic [IDX_W-1:0]  idx_d_s;
   logic              cond_s;
   logic              pcsrc_s;
   logic              mispredict_s;
   logic              update_s;
   logic [STAT_W-1:0] br_cnt_r;
   logic [STAT_W-1:0] miss_cnt_r;
   logic              unused_pc_bits_s;

   // Word-aligned PCs: bits [1:0] and the bits above the index do not
   // participate, so distant PCs alias onto the same counter.
   assign idx_f_s = bus.PC_F[IDX_W+1:2];
   assign idx_d_s = bus.PC_D[IDX_W+1:2];
   assign unused_pc_bits_s = ^{bus.PC_F[PC_W-1:IDX_W+2], bus.PC_F[1:0],
                               bus.PC_D[PC_W-1:IDX_W+2], bus.PC_D[1:0]};

   branch_cond #(
      .DATA_W (DATA_W)
   ) u_cond (
      .BrOp_D (bus.BrOp_D),
      .SrcA_D (bus.SrcA_D),
      .SrcB_D (bus.SrcB_D),
      .cond   (cond_s)
   );

   // Mispredict is deliberately not stall-gated: the consumer qualifies it.
   // A predicted-taken non-branch also mispredicts so Fetch returns to PC_D+4.
   assign pcsrc_s      = bus.Branch_D & cond_s;
   assign mispredict_s = pcsrc_s ^ bus.PredTaken_D;
   assign update_s     = bus.Branch_D & ~bus.Stall_D;

   assign bus.PCSrc_D      = pcsrc_s;
   assign bus.Mispredict_D = mispredict_s;
   // Asynchronous read; same-cycle write to this index becomes visible next cycle
   assign bus.PredTaken_F  = bht_r[idx_f_s][1];
   assign bus.BrCount      = br_cnt_r;
   assign bus.MissCount    = miss_cnt_r;

   // Train the counter of the resolved branch; reset clears every entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            bht_r[i] <= CTR_RST;
         end
      end else if (update_s) begin
         if (pcsrc_s) begin
            bht_r[idx_d_s] <= sat_inc(bht_r[idx_d_s]);
         end else begin
            bht_r[idx_d_s] <= sat_dec(bht_r[idx_d_s]);
         end
      end
   end

   // Saturating statistics; clear wins over a same-cycle increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt_r   <= {STAT_W{1'b0}};
         miss_cnt_r <= {STAT_W{1'b0}};
      end else if (bus.StatClr) begin
         br_cnt_r   <= {STAT_W{1'b0}};
         miss_cnt_r <= {STAT_W{1'b0}};
      end else if (update_s) begin
         if (br_cnt_r != STAT_MAX) begin
            br_cnt_r <= br_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
         end
         if (mispredict_s && (miss_cnt_r != STAT_MAX)) begin
            miss_cnt_r <= miss_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: doc/branch_unit_bht.md
# branch_unit_bht

Decode-stage branch resolution unit with a fetch-side 2-bit branch history table (BHT). It generalises the single-condition branch decision: it evaluates six MIPS branch conditions on forwarded operands, predicts direction for the fetch PC, trains the predictor on resolution and flags mispredictions for pipeline flush. It also keeps saturating branch/mispredict statistics counters. It sits between the Fetch PC logic, the Decode comparator path and the hazard unit.

## Interface
- DATA_W, 32, operand width
- PC_W, 32, program counter width
- BHT_DEPTH, 64, BHT entries; power of two, at least 2
- CTR_INIT, 1, counter reset value (0..3; 1 = weakly not-taken)
- STAT_W, 16, statistics counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PC_F  in  PC_W  fetch PC for lookup
- PredTaken_F  out  1  predicted direction for PC_F
- PC_D  in  PC_W  PC of the instruction in Decode
- PredTaken_D  in  1  prediction carried from Fetch through the F/D register
- Branch_D  in  1  Decode instruction is a conditional branch
- BrOp_D  in  3  condition select: 000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ, 11x reserved
- SrcA_D, SrcB_D  in  DATA_W  forwarded operands (SrcB_D used by BEQ/BNE only)
- Stall_D  in  1  Decode held this cycle
- StatClr  in  1  synchronous clear of statistics
- PCSrc_D  out  1  resolved taken
- Mispredict_D  out  1  resolved direction differs from prediction
- BrCount  out  STAT_W  resolved branches
- MissCount  out  STAT_W  mispredicted branches

## Operation
- Index: IDX_W = log2(BHT_DEPTH). idx_F = PC_F[IDX_W+1:2]. idx_D = PC_D[IDX_W+1:2]. PC[1:0] is ignored.
- Condition logic, combinational. The compare-zero ops are signed compares of SrcA_D against 0:
  - BEQ: A==B
  - BNE: A!=B
  - BLEZ: A<=0
  - BGTZ: A>0
  - BLTZ: A<0
  - BGEZ: A>=0
  - Reserved encodings resolve to not-taken.
- PCSrc_D = Branch_D & cond.
- Mispredict_D = PCSrc_D ^ PredTaken_D. This output is not gated by Stall_D; the consumer gates it. A non-branch that was predicted taken reports a mispredict, so Fetch recovers to PC_D+4.
- PredTaken_F = bit 1 of the counter at idx_F. This is an asynchronous read.
- Update occurs when Branch_D & ~Stall_D, at the clock edge:
  - Taken: counter increments, saturating at 3.
  - Not-taken: counter decrements, saturating at 0.
  - No other entry changes.
- Statistics update when Branch_D & ~Stall_D:
  - BrCount increments, saturating at all-ones.
  - MissCount increments if Mispredict_D, saturating at all-ones.
  - StatClr zeroes both counters and takes priority over any increment in the same cycle.

## Timing
- Reset (async assert, sync-safe deassert by upstream): every BHT entry resets to CTR_INIT, and BrCount and MissCount reset to 0.
- Output values during reset:
  - PredTaken_F = CTR_INIT[1].
  - PCSrc_D and Mispredict_D follow their inputs combinationally.
- PCSrc_D, Mispredict_D and PredTaken_F have zero-cycle latency.
- BHT write latency is 1 cycle: a lookup in the cycle after the update edge sees the new value.
- If idx_F == idx_D in an update cycle, PredTaken_F returns the old value (read-before-write).
- Stall_D=1 blocks all BHT and statistics writes, even when a branch is present. The held branch updates once, in the cycle Stall_D falls.
- Reset asserted mid-operation discards any pending update. There is no partial state.

## Structure
- Package branch_pkg holds:
  - BrOp encodings (BR_BEQ..BR_BGEZ)
  - counter constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3
  - a sat_inc/sat_dec helper for 2-bit values
- Sub-module branch_cond: pure combinational (BrOp_D, SrcA_D, SrcB_D) -> cond, parametrised on DATA_W.
- BHT is a flop array with reset. No RAM macro is used, so that reset clears every entry.

## Test plan
- Reset with CTR_INIT=1 -> PredTaken_F=0 for all indices; BrCount=MissCount=0.
- Condition coverage: BrOp 010 (BLEZ), SrcA=0x00000000 -> PCSrc_D=1; BrOp 011 (BGTZ), SrcA=0x80000000 -> PCSrc_D=0; BrOp 101 (BGEZ), SrcA=0x7FFFFFFF -> PCSrc_D=1; BrOp 110, any operands -> PCSrc_D=0.
- Training:
  - Repeated taken BEQ at PC_D=0x40 with SrcA=SrcB=5: the 1st update moves the counter to 2, so PredTaken_F for PC_F=0x40 reads 1 on the next cycle.
  - The 3rd update saturates the counter at 3.
  - One not-taken update then gives 2, and the prediction stays 1.
- Aliasing with BHT_DEPTH=64: an update at PC_D=0x40 with the counter at 1 changes the prediction for PC_F=0x140 in the same way.
- Same-cycle read/write at idx 16: an update (counter 1 -> 2) reads PredTaken_F=0 in that cycle and 1 in the next.
- Stall and stats:
  - A taken branch with Stall_D=1 for 3 cycles leaves BrCount and the BHT unchanged, then increments once when the stall drops.
  - With STAT_W=4, 20 mispredicted branches give BrCount=MissCount=15.
  - StatClr asserted together with a branch gives 0.
